// File: rtl/cc_branch_controller.sv
// cc_branch_controller: condition-code sequencing and branch resolution.
// Holds one decoded instruction at a time; pulses ldcc, br_valid, done, wb_timeout.
module cc_branch_controller #(
   parameter int WB_TIMEOUT  = 15,
   parameter bit LEA_SETS_CC = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_instr_valid,
   output logic        o_instr_ready,
   input  logic [15:0] i_instr,
   input  logic        i_bus_valid,
   input  logic [2:0]  i_nzp,
   output logic        o_ldcc,
   output logic        o_br_valid,
   output logic        o_br_taken,
   output logic        o_done,
   output logic        o_wb_timeout
);

   localparam int CW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WB_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_WB,
      S_EVAL,
      S_RETIRE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    r_cond;
   logic [2:0]    w_cond_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          r_br_valid;
   logic          w_br_valid_nxt;
   logic          r_br_taken;
   logic          w_br_taken_nxt;
   logic          r_timeout;
   logic          w_timeout_nxt;
   logic [3:0]    w_op;
   logic          w_is_cc;
   logic          w_unused;

   // Only the branch condition field survives past accept.
   assign w_op     = i_instr[15:12];
   assign w_unused = ^i_instr[8:0];

   // Opcode classification: does this instruction load the CC register?
   always_comb begin
      w_is_cc = 1'b0;
      case (w_op)
         4'b0001, 4'b0101, 4'b1001,
         4'b0010, 4'b1010, 4'b0110: w_is_cc = 1'b1;
         4'b1110:                   w_is_cc = LEA_SETS_CC;
         default:                   w_is_cc = 1'b0;
      endcase
   end

   // Next-state and registered-pulse logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_cond_nxt     = r_cond;
      w_done_nxt     = 1'b0;
      w_br_valid_nxt = 1'b0;
      w_br_taken_nxt = 1'b0;
      w_timeout_nxt  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_instr_valid) begin
               w_cond_nxt = i_instr[11:9];
               w_cnt_nxt  = '0;
               if (w_is_cc)
                  w_state_nxt = S_WAIT_WB;
               else if (w_op == 4'b0000)
                  w_state_nxt = S_EVAL;
               else
                  w_state_nxt = S_RETIRE;
            end
         end
         S_WAIT_WB: begin
            if (i_bus_valid) begin
               w_done_nxt  = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout_nxt = 1'b1;
               w_cnt_nxt     = '0;
               w_state_nxt   = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_EVAL: begin
            w_br_taken_nxt = |(r_cond & i_nzp);
            w_br_valid_nxt = 1'b1;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
         end
         S_RETIRE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, counter, latched condition and pulse registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cond     <= '0;
         r_done     <= 1'b0;
         r_br_valid <= 1'b0;
         r_br_taken <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_cond     <= w_cond_nxt;
         r_done     <= w_done_nxt;
         r_br_valid <= w_br_valid_nxt;
         r_br_taken <= w_br_taken_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // ldcc is same-cycle so the CC register samples the bus at this edge.
   assign o_ldcc        = !i_reset && (r_state == S_WAIT_WB) && i_bus_valid;
   assign o_instr_ready = (r_state == S_IDLE);
   assign o_done        = r_done;
   assign o_br_valid    = r_br_valid;
   assign o_br_taken    = r_br_taken;
   assign o_wb_timeout  = r_timeout;

endmodule

// File: tb/tb_cc_branch_controller.sv
// tb_cc_branch_controller: two parameterisations driven with shared stimulus,
// checked against a transaction-level model plus directed expectations.
module tb_cc_branch_controller;

   localparam int A_TO  = 15;
   localparam bit A_LEA = 1'b1;
   localparam int B_TO  = 4;
   localparam bit B_LEA = 1'b0;

   logic        clk;
   logic        reset;
   logic        ivalid;
   logic [15:0] instr;
   logic        bus;
   logic [2:0]  nzp;
   logic [15:0] bus_data;
   bit          use_cc;

   logic a_ready, a_ldcc, a_brv, a_brt, a_done, a_to;
   logic b_ready, b_ldcc, b_brv, b_brt, b_done, b_to;
   logic obs_ldcc_a, obs_ldcc_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: per instance, is an instruction in flight, of which kind,
   // how many write-back cycles have elapsed, and the pending pulses.
   int       m_to[2]  = '{A_TO, B_TO};
   bit       m_lea[2] = '{A_LEA, B_LEA};
   bit       m_busy[2];
   int       m_kind[2];
   int       m_wait[2];
   bit [2:0] m_cond[2];
   bit       m_done[2];
   bit       m_brv[2];
   bit       m_brt[2];
   bit       m_tout[2];

   cc_branch_controller #(.WB_TIMEOUT(A_TO), .LEA_SETS_CC(A_LEA)) dut_a (
      .i_clk(clk), .i_reset(reset), .i_instr_valid(ivalid),
      .o_instr_ready(a_ready), .i_instr(instr), .i_bus_valid(bus),
      .i_nzp(nzp), .o_ldcc(a_ldcc), .o_br_valid(a_brv),
      .o_br_taken(a_brt), .o_done(a_done), .o_wb_timeout(a_to)
   );

   cc_branch_controller #(.WB_TIMEOUT(B_TO), .LEA_SETS_CC(B_LEA)) dut_b (
      .i_clk(clk), .i_reset(reset), .i_instr_valid(ivalid),
      .o_instr_ready(b_ready), .i_instr(instr), .i_bus_valid(bus),
      .i_nzp(nzp), .o_ldcc(b_ldcc), .o_br_valid(b_brv),
      .o_br_taken(b_brt), .o_done(b_done), .o_wb_timeout(b_to)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit sets_cc(input logic [3:0] op, input bit lea);
      return (op == 4'h1) || (op == 4'h5) || (op == 4'h9) ||
             (op == 4'h2) || (op == 4'hA) || (op == 4'h6) ||
             (lea && op == 4'hE);
   endfunction

   function automatic logic [2:0] cc_of(input logic [15:0] d);
      if (d[15]) return 3'b100;
      if (d == 16'h0) return 3'b010;
      return 3'b001;
   endfunction

   function automatic bit exp_ldcc(input int i);
      return !reset && m_busy[i] && m_kind[i] == 0 && bus;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int i);
      m_done[i] = 0;
      m_brv[i]  = 0;
      m_brt[i]  = 0;
      m_tout[i] = 0;
      if (reset) begin
         m_busy[i] = 0;
         m_cond[i] = 0;
         m_wait[i] = 0;
      end else if (!m_busy[i]) begin
         if (ivalid) begin
            m_busy[i] = 1;
            m_wait[i] = 0;
            m_cond[i] = instr[11:9];
            if (sets_cc(instr[15:12], m_lea[i])) m_kind[i] = 0;
            else if (instr[15:12] == 4'h0) m_kind[i] = 1;
            else m_kind[i] = 2;
         end
      end else if (m_kind[i] == 0) begin
         if (bus) begin
            m_done[i] = 1;
            m_busy[i] = 0;
         end else begin
            m_wait[i]++;
            if (m_wait[i] == m_to[i]) begin
               m_tout[i] = 1;
               m_busy[i] = 0;
            end
         end
      end else begin
         if (m_kind[i] == 1) begin
            m_brv[i] = 1;
            m_brt[i] = |(m_cond[i] & nzp);
         end
         m_done[i] = 1;
         m_busy[i] = 0;
      end
   endtask

   // One clock: check combinational outputs mid-cycle, clock, check pulses.
   task automatic step();
      bit la;
      @(negedge clk);
      obs_ldcc_a = a_ldcc;
      obs_ldcc_b = b_ldcc;
      la = exp_ldcc(0);
      chk("a_ready", a_ready, !m_busy[0]);
      chk("b_ready", b_ready, !m_busy[1]);
      chk("a_ldcc", a_ldcc, exp_ldcc(0));
      chk("b_ldcc", b_ldcc, exp_ldcc(1));
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk("a_done", a_done, m_done[0]);
      chk("b_done", b_done, m_done[1]);
      chk("a_br_valid", a_brv, m_brv[0]);
      chk("b_br_valid", b_brv, m_brv[1]);
      chk("a_wb_timeout", a_to, m_tout[0]);
      chk("b_wb_timeout", b_to, m_tout[1]);
      if (m_brv[0]) chk("a_br_taken", a_brt, m_brt[0]);
      if (m_brv[1]) chk("b_br_taken", b_brt, m_brt[1]);
      if (use_cc && la) nzp = cc_of(bus_data);
   endtask

   task automatic issue(input logic [15:0] w);
      ivalid = 1'b1;
      instr  = w;
      step();
      ivalid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] ops[10];
      ops = '{4'h0, 4'h1, 4'h5, 4'h9, 4'h2, 4'hA, 4'h6, 4'hE, 4'hC, 4'h4};
      reset = 1'b1; ivalid = 1'b0; instr = '0; bus = 1'b0;
      nzp = 3'b000; bus_data = '0; use_cc = 1;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      step();

      // Reset held two cycles in WAIT_WB with bus_valid high.
      reset = 1'b0;
      issue(16'h1261);
      bus = 1'b1;
      reset = 1'b1;
      step();
      chk("t1_ldcc_0", obs_ldcc_a, 1'b0);
      step();
      chk("t1_ldcc_1", obs_ldcc_a, 1'b0);
      chk("t1_done", a_done, 1'b0);
      chk("t1_tout", a_to, 1'b0);
      reset = 1'b0;
      bus = 1'b0;
      step();
      chk("t1_ready", a_ready, 1'b1);
      chk("t1_ready_b", b_ready, 1'b1);

      // ADD, result 0x8000 arrives on the bus three cycles later.
      bus_data = 16'h8000;
      issue(16'h1261);
      step();
      chk("t2_ldcc_lo", obs_ldcc_a, 1'b0);
      step();
      bus = 1'b1;
      step();
      bus = 1'b0;
      chk("t2_ldcc_hi", obs_ldcc_a, 1'b1);
      chk("t2_done", a_done, 1'b1);
      chk("t2_nzp", nzp, 3'b100);

      // BRz with nzp=010 then nzp=001.
      nzp = 3'b010;
      issue(16'h0405);
      step();
      chk("t3_brv", a_brv, 1'b1);
      chk("t3_taken", a_brt, 1'b1);
      chk("t3_done", a_done, 1'b1);
      nzp = 3'b001;
      issue(16'h0405);
      step();
      chk("t3_brv2", a_brv, 1'b1);
      chk("t3_taken2", a_brt, 1'b0);
      chk("t3_done2", a_done, 1'b1);

      // Condition field 000 never taken, 111 always taken.
      nzp = 3'b111;
      issue(16'h0000);
      step();
      chk("t4_never", a_brt, 1'b0);
      nzp = 3'b100;
      issue(16'h0E00);
      step();
      chk("t4_always", a_brt, 1'b1);

      // Timeout on the WB_TIMEOUT=4 instance, then a retry that makes it.
      issue(16'h6285);
      repeat (3) step();
      chk("t5_no_tout_yet", b_to, 1'b0);
      step();
      chk("t5_tout", b_to, 1'b1);
      chk("t5_no_done", b_done, 1'b0);
      do_reset();
      bus_data = 16'h0000;
      issue(16'h6285);
      repeat (3) step();
      bus = 1'b1;
      step();
      bus = 1'b0;
      chk("t5_ldcc", obs_ldcc_b, 1'b1);
      chk("t5_done", b_done, 1'b1);
      chk("t5_no_tout", b_to, 1'b0);
      chk("t5_nzp", nzp, 3'b010);

      // ADD result 0x0001, then BRp sees the fresh CC.
      bus_data = 16'h0001;
      issue(16'h1261);
      bus = 1'b1;
      step();
      bus = 1'b0;
      issue(16'h0201);
      step();
      chk("t6_nzp", nzp, 3'b001);
      chk("t6_brp_a", a_brt, 1'b1);
      chk("t6_brp_b", b_brt, 1'b1);

      // LEA: retires directly on the LEA_SETS_CC=0 instance.
      issue(16'hE000);
      step();
      chk("t6_lea_done_b", b_done, 1'b1);
      chk("t6_lea_ldcc_b", obs_ldcc_b, 1'b0);
      chk("t6_lea_busy_a", a_ready, 1'b0);
      do_reset();
      issue(16'hC1C0);
      step();
      chk("t6_jmp_done", a_done, 1'b1);
      chk("t6_jmp_brv", a_brv, 1'b0);

      // Random traffic against the model.
      use_cc = 0;
      for (int k = 0; k < 600; k++) begin
         reset  = ($urandom_range(0, 59) == 0);
         ivalid = $urandom_range(0, 1);
         instr  = 16'($urandom);
         instr[15:12] = ops[$urandom_range(0, 9)];
         if (k < 300) bus = ($urandom_range(0, 3) == 0);
         else bus = ($urandom_range(0, 19) == 0);
         nzp = 3'($urandom);
         step();
      end
      reset = 1'b0;
      ivalid = 1'b0;
      bus = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
